ex_hazard_sequencer: RTL and testbench
======================================

Name: ex_hazard_sequencer

Overview:
Hazard and sequencing controller for the five-stage pipeline's execute stage.
- Generates the EX operand-forward selects, the load-use stall and the branch/jump flush.
- Sequences a fixed-latency multi-cycle EX operation class (MUL/DIV) by freezing F/D/E and bubbling MEM until the operation completes.
- Keeps stall and flush performance counters.

Parameters:
MC_CYCLES, 4, EX occupancy in cycles of a multi-cycle op; legal range 2..16.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
rs1_d  input  5  rs1 of the instruction in decode.
rs2_d  input  5  rs2 of the instruction in decode.
rs1_e  input  5  rs1 of the instruction in EX.
rs2_e  input  5  rs2 of the instruction in EX.
rd_e  input  5  rd of the instruction in EX.
result_src_e  input  2  EX result source; 2'b01 means load.
pc_src_e  input  1  taken branch or jump resolved in EX.
mc_op_e  input  1  EX instruction is multi-cycle class.
rd_m  input  5  rd in MEM.
regwrite_m  input  1  MEM instruction writes the register file.
rd_w  input  5  rd in WB.
regwrite_w  input  1  WB instruction writes the register file.
forward_operand_a_e  output  2  operand A select: 00 regfile, 01 result_w, 10 alu_result_m.
forward_operand_b_e  output  2  operand B select, same encoding.
stall_f  output  1  hold PC.
stall_d  output  1  hold the IF/ID register.
stall_e  output  1  hold the ID/EX register.
flush_d  output  1  clear the IF/ID register.
flush_e  output  1  clear the ID/EX register (bubble into EX).
flush_m  output  1  clear the EX/MEM register (bubble into MEM).
mc_start  output  1  one-cycle pulse; the multi-cycle unit latches forwarded operands.
mc_busy  output  1  FSM in BUSY.
stall_count  output  CNT_W  cycles with stall_f asserted.
flush_count  output  CNT_W  cycles with flush_d asserted.

Behaviour:
Forwarding (combinational, per operand, shown for A):
- 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
- Else 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
- Else 00.
- MEM has priority over WB. Register x0 is never forwarded.

Load-use:
- lu = result_src_e==2'b01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- Response: stall_f=stall_d=1, flush_e=1.

Control flow:
- When pc_src_e=1: flush_d=1, flush_e=1, stall_f=stall_d=0.
- pc_src_e overrides lu.

Multi-cycle FSM, states IDLE and BUSY, counter cnt of 4 bits:
- IDLE && mc_op_e && !pc_src_e:
  - mc_start=1; stall_f=stall_d=stall_e=1; flush_m=1.
  - Next state BUSY with cnt=MC_CYCLES-2.
- BUSY && cnt!=0:
  - stall_f=stall_d=stall_e=1; flush_m=1; cnt decrements.
- BUSY && cnt==0:
  - No stall and no flush_m; the result enters EX/MEM at this edge.
  - Next state IDLE.
- Total EX occupancy is exactly MC_CYCLES cycles; mc_start pulses once per op.
- Back-to-back multi-cycle ops: the next op is seen in IDLE on the following cycle and restarts normally.
- While BUSY, lu and pc_src_e are ignored. A multi-cycle op is never a load or a branch; decode hazards re-evaluate after release.
- mc_busy = (state==BUSY).

Priority of output drive: reset, then BUSY/mc_start stall, then pc_src_e flush, then lu stall.

Counters:
- Increment at posedge when the respective signal is 1.
- Wrap modulo 2^CNT_W.

Reset (async):
- state=IDLE, cnt=0, counters=0.
- All combinational outputs evaluate with state IDLE.
- Reset mid-BUSY aborts the op; no further stall is issued.

Test Plan:
- add x5 in MEM (regwrite_m=1, rd_m=5) and WB also rd_w=5; EX rs1_e=5, rs2_e=0 -> forward_a=10, forward_b=00.
- lw x7 in EX (result_src_e=01, rd_e=7), decode rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly that cycle; stall_count +1. Repeat with rd_e=0 -> no stall.
- pc_src_e=1 coincident with a load-use condition -> flush_d=flush_e=1, stall_f=0; flush_count +1.
- mc_op_e=1 with MC_CYCLES=4 -> mc_start pulses in cycle 0; stall_e and flush_m high in cycles 0-2, low in cycle 3; mc_busy high in cycles 1-3; state IDLE in cycle 4.
- Two consecutive multi-cycle ops -> two mc_start pulses 4 cycles apart; stalls total 6 cycles.
- Assert reset in cycle 1 of BUSY -> all stalls drop immediately, mc_busy=0, counters=0; the next mc_op_e starts a fresh 4-cycle sequence.

Source files
------------

// File: rtl/ex_hazard_sequencer.sv
// Execute-stage hazard and sequencing controller: operand forwarding selects,
// load-use stall, branch/jump flush, fixed-latency multi-cycle op sequencing
// and stall/flush performance counters.
module ex_hazard_sequencer #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       result_src_e,
  input  logic             pc_src_e,
  input  logic             mc_op_e,
  input  logic [4:0]       rd_m,
  input  logic             regwrite_m,
  input  logic [4:0]       rd_w,
  input  logic             regwrite_w,
  output logic [1:0]       forward_operand_a_e,
  output logic [1:0]       forward_operand_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             mc_start,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The start cycle and the final release cycle are not counted by cnt,
  // so the op occupies EX for cnt_load + 2 cycles in total.
  localparam logic [3:0] CNT_LOAD = 4'(MC_CYCLES - 2);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       load_use;

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwrite_m && rd_m != 5'd0 && rd_m == rs)      fwd_sel = 2'b10;
    else if (regwrite_w && rd_w != 5'd0 && rd_w == rs) fwd_sel = 2'b01;
    else                                               fwd_sel = 2'b00;
  endfunction

  // Operand forward selects for the instruction in EX.
  always_comb begin
    forward_operand_a_e = fwd_sel(rs1_e);
    forward_operand_b_e = fwd_sel(rs2_e);
  end

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    load_use = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

  // State and occupancy counter; reset aborts any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and stall/flush drive; a busy multi-cycle op outranks
  // control-flow flushes, which outrank load-use stalls.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    mc_start   = 1'b0;
    mc_busy    = (state == BUSY);
    case (state)
      IDLE: begin
        if (mc_op_e && !pc_src_e) begin
          mc_start   = 1'b1;
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_e    = 1'b1;
          flush_m    = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end else if (pc_src_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_f) stall_count <= stall_count + 1'b1;
      if (flush_d) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Self-checking bench for ex_hazard_sequencer: fixed vectors, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_ex_hazard_sequencer;

  localparam int MC = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic pc_src_e, mc_op_e, regwrite_m, regwrite_w;
  logic [1:0] fa, fb;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_start, mc_busy;
  logic [CW-1:0] stall_count, flush_count;

  ex_hazard_sequencer #(.MC_CYCLES(MC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .mc_op_e(mc_op_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .forward_operand_a_e(fa), .forward_operand_b_e(fb),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mc_start(mc_start), .mc_busy(mc_busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: position within the current multi-cycle op (0 = none) and
  // expected counter values.
  int m_pos;
  int m_stalls;
  int m_flushes;

  // Last sampled outputs, for multi-cycle pattern checks.
  logic s_start, s_stall_e, s_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Check the current cycle against the model, advance the model, then
  // move to the next falling edge where new inputs are driven.
  task automatic step();
    logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_start, e_busy, lu;
    #1;
    e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0; e_start = 0;
    e_busy = (m_pos != 0);
    lu = (result_src_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (m_pos == 0 && mc_op_e && !pc_src_e) begin
      e_start = 1; e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
    end else if (m_pos != 0) begin
      if (m_pos < MC - 1) begin e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1; end
    end else if (pc_src_e) begin
      e_fd = 1; e_fe = 1;
    end else if (lu) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
    chk("fwd_a", 64'(fa), 64'(m_fwd(rs1_e)));
    chk("fwd_b", 64'(fb), 64'(m_fwd(rs2_e)));
    chk("stall_f", 64'(stall_f), 64'(e_sf));
    chk("stall_d", 64'(stall_d), 64'(e_sd));
    chk("stall_e", 64'(stall_e), 64'(e_se));
    chk("flush_d", 64'(flush_d), 64'(e_fd));
    chk("flush_e", 64'(flush_e), 64'(e_fe));
    chk("flush_m", 64'(flush_m), 64'(e_fm));
    chk("mc_start", 64'(mc_start), 64'(e_start));
    chk("mc_busy", 64'(mc_busy), 64'(e_busy));
    chk("stall_count", 64'(stall_count), 64'(m_stalls));
    chk("flush_count", 64'(flush_count), 64'(m_flushes));
    s_start = mc_start; s_stall_e = stall_e; s_busy = mc_busy;
    if (e_sf) m_stalls++;
    if (e_fd) m_flushes++;
    if (e_start) m_pos = 1;
    else if (m_pos != 0) m_pos = (m_pos == MC - 1) ? 0 : m_pos + 1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    result_src_e = 0; pc_src_e = 0; mc_op_e = 0; regwrite_m = 0; regwrite_w = 0;
  endtask

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src;
    logic       pc_src, regwrite_m, regwrite_w;
    logic [1:0] exp_fa, exp_fb;
    logic       exp_sf, exp_fd, exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] p_start, p_stall_e, p_busy;
    logic [7:0] b_start;
    int s0;

    //              rs1d rs2d rs1e rs2e rde rdm rdw src pc rwm rww fa    fb    sf fd fe
    vecs[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd0, 5'd0, 5'd3, 5'd6, 5'd0, 5'd9, 5'd6, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    clear_inputs();
    reset = 1'b1;
    m_pos = 0; m_stalls = 0; m_flushes = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(mc_busy), 64'd0);
    chk("reset_stall_count", 64'(stall_count), 64'd0);
    chk("reset_flush_count", 64'(flush_count), 64'd0);
    chk("reset_stall_f", 64'(stall_f), 64'd0);
    reset = 1'b0;

    // Fixed vectors in the idle state.
    for (int i = 0; i < 8; i++) begin
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e; rd_e = vecs[i].rd_e;
      rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w; result_src_e = vecs[i].result_src;
      pc_src_e = vecs[i].pc_src; regwrite_m = vecs[i].regwrite_m;
      regwrite_w = vecs[i].regwrite_w; mc_op_e = 1'b0;
      #1;
      chk($sformatf("vec%0d_fa", i), 64'(fa), 64'(vecs[i].exp_fa));
      chk($sformatf("vec%0d_fb", i), 64'(fb), 64'(vecs[i].exp_fb));
      chk($sformatf("vec%0d_stall_f", i), 64'(stall_f), 64'(vecs[i].exp_sf));
      chk($sformatf("vec%0d_flush_d", i), 64'(flush_d), 64'(vecs[i].exp_fd));
      chk($sformatf("vec%0d_flush_e", i), 64'(flush_e), 64'(vecs[i].exp_fe));
      step();
    end
    // One load-use stall (vec4) and one flush (vec6) were counted.
    chk("vec_stall_count", 64'(stall_count), 64'd1);
    chk("vec_flush_count", 64'(flush_count), 64'd1);

    // Single multi-cycle op.
    clear_inputs();
    mc_op_e = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      p_start[c] = s_start; p_stall_e[c] = s_stall_e; p_busy[c] = s_busy;
    end
    chk("mc_start_pattern", 64'(p_start), 64'b0001);
    chk("mc_stall_e_pattern", 64'(p_stall_e), 64'b0111);
    chk("mc_busy_pattern", 64'(p_busy), 64'b1110);
    mc_op_e = 1'b0;
    step();
    chk("mc_idle_after", 64'(s_busy), 64'd0);

    // Two back-to-back multi-cycle ops.
    s0 = int'(stall_count);
    mc_op_e = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      b_start[c] = s_start;
    end
    mc_op_e = 1'b0;
    step();
    chk("b2b_start_pattern", 64'(b_start), 64'b00010001);
    chk("b2b_stall_cycles", 64'(int'(stall_count) - s0), 64'd6);

    // Reset asserted in the first BUSY cycle.
    mc_op_e = 1'b1;
    step();
    mc_op_e = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_stall_f", 64'(stall_f), 64'd0);
    chk("rst_mid_stall_e", 64'(stall_e), 64'd0);
    chk("rst_mid_flush_m", 64'(flush_m), 64'd0);
    chk("rst_mid_busy", 64'(mc_busy), 64'd0);
    chk("rst_mid_stall_count", 64'(stall_count), 64'd0);
    chk("rst_mid_flush_count", 64'(flush_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_pos = 0; m_stalls = 0; m_flushes = 0;
    mc_op_e = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      p_start[c] = s_start; p_stall_e[c] = s_stall_e; p_busy[c] = s_busy;
    end
    chk("post_rst_start_pattern", 64'(p_start), 64'b0001);
    chk("post_rst_busy_pattern", 64'(p_busy), 64'b1110);
    mc_op_e = 1'b0;
    step();

    // Random traffic over a small register range so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      rs1_d = 5'($urandom_range(3)); rs2_d = 5'($urandom_range(3));
      rs1_e = 5'($urandom_range(3)); rs2_e = 5'($urandom_range(3));
      rd_e  = 5'($urandom_range(3)); rd_m  = 5'($urandom_range(3));
      rd_w  = 5'($urandom_range(3));
      result_src_e = 2'($urandom_range(3));
      pc_src_e   = ($urandom_range(5) == 0);
      mc_op_e    = ($urandom_range(7) == 0);
      regwrite_m = 1'($urandom_range(1));
      regwrite_w = 1'($urandom_range(1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
